// File: rtl/sram_arb_pkg.sv
// Shared encodings for the two-port SRAM arbiter: arbiter states,
// owner codes and the width of the locked-burst counter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_A = 2'd1,
    ST_LOCK_B = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_A    = 2'b01,
    OWN_B    = 2'b10
  } owner_e;

  localparam int BURST_W = 4;

endpackage

// File: rtl/sram.sv
// Single-port SRAM: write committed on the rising edge, read is
// asynchronous so a word written last cycle is visible immediately.
module sram #(
  parameter int ADDR  = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic [ADDR-1:0]  addr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             write_en,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR)-1];

  // Commit a write at the clock edge of the acceptance cycle
  always_ff @(posedge clk) begin
    if (write_en) mem[addr] <= data_in;
  end

  assign data_out = mem[addr];

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of one SRAM, with optional locked bursts.
// Build option: define SRAM_ARB_RR_EN for round-robin contention in
// IDLE; otherwise port A has fixed priority over port B.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR      = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic             a_we,
  input  logic             a_lock,
  input  logic [ADDR-1:0]  a_addr,
  input  logic [WIDTH-1:0] a_wdata,
  input  logic             b_valid,
  input  logic             b_we,
  input  logic             b_lock,
  input  logic [ADDR-1:0]  b_addr,
  input  logic [WIDTH-1:0] b_wdata,
  output logic             a_ready,
  output logic             b_ready,
  output logic             a_rvalid,
  output logic             b_rvalid,
  output logic [WIDTH-1:0] a_rdata,
  output logic [WIDTH-1:0] b_rdata,
  output logic [1:0]       owner
);

  localparam logic [BURST_W-1:0] MAX_CNT = BURST_W'(MAX_BURST);

  arb_state_e         state;
  logic [BURST_W-1:0] burst_cnt;
  logic [BURST_W-1:0] cnt_inc;
  logic               grant_a, grant_b, take, lock_hold, go_lock;
  logic               sel_we, sel_lock;
  logic [ADDR-1:0]    sel_addr, addr_hold, sram_addr;
  logic [WIDTH-1:0]   sel_wdata, sram_dout;
  logic               sram_we;
  logic               rvalid_a_p1, rvalid_b_p1;
  logic [WIDTH-1:0]   rdata_a_p1, rdata_b_p1;
`ifdef SRAM_ARB_RR_EN
  logic               last_b;
`endif

  // Grant decision: a locked owner keeps the port while it stays valid;
  // a locked owner dropping valid reopens arbitration in the same cycle
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst_n) begin
      grant_a = 1'b0;
    end else if (state == ST_LOCK_A && a_valid) begin
      grant_a = 1'b1;
    end else if (state == ST_LOCK_B && b_valid) begin
      grant_b = 1'b1;
    end else if (a_valid && b_valid) begin
`ifdef SRAM_ARB_RR_EN
      grant_a = last_b;
      grant_b = !last_b;
`else
      grant_a = 1'b1;
`endif
    end else begin
      grant_a = a_valid;
      grant_b = b_valid;
    end
  end

  assign take      = grant_a | grant_b;
  assign sel_we    = grant_b ? b_we    : a_we;
  assign sel_lock  = grant_b ? b_lock  : a_lock;
  assign sel_addr  = grant_b ? b_addr  : a_addr;
  assign sel_wdata = grant_b ? b_wdata : a_wdata;

  // A burst only continues counting if the lock owner is still present;
  // a combinational release starts the new owner from zero
  assign lock_hold = (state == ST_LOCK_A && a_valid) || (state == ST_LOCK_B && b_valid);
  assign cnt_inc   = (lock_hold ? burst_cnt : '0) + 1'b1;
  assign go_lock   = take && sel_lock && (cnt_inc < MAX_CNT);

  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign owner     = grant_a ? OWN_A : (grant_b ? OWN_B : OWN_NONE);
  assign sram_we   = take & sel_we;
  assign sram_addr = take ? sel_addr : addr_hold;

  // Arbiter state and burst counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      burst_cnt <= '0;
    end else if (go_lock) begin
      state     <= grant_a ? ST_LOCK_A : ST_LOCK_B;
      burst_cnt <= cnt_inc;
    end else begin
      state     <= ST_IDLE;
      burst_cnt <= '0;
    end
  end

`ifdef SRAM_ARB_RR_EN
  // Remember which port took the last transfer; B at reset so A wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_b <= 1'b1;
    else if (take) last_b <= grant_b;
  end
`endif

  // Keep the SRAM address stable while nobody is granted
  always_ff @(posedge clk) begin
    if (take) addr_hold <= sel_addr;
  end

  // Read return, stage p0 -> p1: sample SRAM output in the acceptance cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_a_p1 <= 1'b0;
      rvalid_b_p1 <= 1'b0;
      rdata_a_p1  <= '0;
      rdata_b_p1  <= '0;
    end else begin
      rvalid_a_p1 <= grant_a & !a_we;
      rvalid_b_p1 <= grant_b & !b_we;
      if (grant_a && !a_we) rdata_a_p1 <= sram_dout;
      if (grant_b && !b_we) rdata_b_p1 <= sram_dout;
    end
  end

  assign a_rvalid = rvalid_a_p1;
  assign b_rvalid = rvalid_b_p1;
  assign a_rdata  = rdata_a_p1;
  assign b_rdata  = rdata_b_p1;

  sram #(
    .ADDR  (ADDR),
    .WIDTH (WIDTH)
  ) u_sram (
    .clk      (clk),
    .addr     (sram_addr),
    .data_in  (sel_wdata),
    .write_en (sram_we),
    .data_out (sram_dout)
  );

endmodule
